uart_receiver: RTL

Serial-to-parallel UART receiver for the chip_top host link. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the `rx` pin and presents each byte on a valid/ready interface to the pixel ingest path. It detects false starts, framing errors and overrun. It is the receiving end of the host byte stream, with one bit lasting 32 clocks at the default rate.

---
 rtl/uart_receiver.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: 2-flop input synchronizer, mid-bit sampling FSM,
// valid/ready byte delivery with false-start, framing-error and overrun detection.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 32,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state, state_n;
  logic                 sync1, rx_s;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 stop_ok, stop_bad;

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        // Counter wraps every bit period; the FSM only leaves after the last bit.
        if (cnt == CNT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[DATA_BITS-1:1]};
          bit_idx_n = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_LAST) state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n    = '0;
          stop_ok  = rx_s;
          stop_bad = ~rx_s;
          state_n  = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

  // A held byte is never overwritten; a new byte arriving then is counted as overrun.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= stop_bad;
      overrun     <= 1'b0;
      if (stop_ok) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
